// File: rtl/uart_tx_param.sv
// Purpose: parametrised UART transmitter (5..9 data bits, none/odd/even parity, 1/2 stop) with line-break generation.
// Latency: start bit drives tx from the edge after the hold register fills; every line bit lasts DIV clk cycles.
// Backpressure: one-entry hold register; tx_ready low while it is full, so frames run back-to-back without idle cycles.
module uart_tx_param #(
    parameter int CLOCK     = 25000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 break_req,
    output logic                 tx,
    output logic                 busy
);

    localparam int DIV       = (CLOCK + BAUD / 2) / BAUD;
    localparam int CW        = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int FRAME_LEN = (1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS) * DIV;
    localparam int BRK_W     = $clog2(FRAME_LEN);

    localparam logic [CW-1:0]    BAUD_LAST = CW'(DIV - 1);
    localparam logic [BRK_W-1:0] BRK_LAST  = BRK_W'(FRAME_LEN - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    // Reject configurations the line format cannot represent.
    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx_param: CLOCK/BAUD gives a divider below 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_tx_param: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        baud_cnt, baud_nxt;
    logic [3:0]           bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [DATA_BITS-1:0] hold_dat, hold_dat_nxt;
    logic                 hold_full, hold_full_nxt;
    logic                 par_bit, par_nxt;
    logic [BRK_W-1:0]     brk_cnt, brk_nxt;
    logic                 tx_nxt;
    logic                 bit_end;
    logic                 accept;
    logic                 load;

    assign bit_end  = (baud_cnt == BAUD_LAST);
    assign accept   = tx_valid & ~hold_full;
    assign tx_ready = ~hold_full;
    assign busy     = (state != S_IDLE) | hold_full;

    // Next-state, shifter, hold register and registered line level.
    always_comb begin
        state_nxt     = state;
        bit_nxt       = bit_cnt;
        shreg_nxt     = shreg;
        par_nxt       = par_bit;
        brk_nxt       = brk_cnt;
        baud_nxt      = '0;
        load          = 1'b0;
        tx_nxt        = 1'b1;
        hold_dat_nxt  = hold_dat;
        hold_full_nxt = hold_full;

        case (state)
            S_IDLE: begin
                // A waiting word wins over a break request.
                if (hold_full) begin
                    load = 1'b1;
                end else if (break_req) begin
                    state_nxt = S_BREAK;
                    brk_nxt   = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt = S_DATA;
                    bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt   = bit_cnt + 4'd1;
                        shreg_nxt = shreg >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_nxt = S_STOP;
                    bit_nxt   = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        // Chain straight into the next start bit when a word is waiting.
                        if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        bit_nxt = bit_cnt + 4'd1;
                    end
                end
            end
            S_BREAK: begin
                // Break lasts at least one frame time and as long as the request is held.
                if (brk_cnt != BRK_LAST) begin
                    brk_nxt = brk_cnt + BRK_W'(1);
                end else if (!break_req) begin
                    state_nxt = S_STOP;
                    bit_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (load) begin
            state_nxt = S_START;
            shreg_nxt = hold_dat;
            par_nxt   = (PARITY == 1) ? ~^hold_dat : ^hold_dat;
        end

        // Divider only runs inside a bit time, so each frame starts phase-aligned.
        if (state != S_IDLE && state != S_BREAK && !bit_end) begin
            baud_nxt = baud_cnt + CW'(1);
        end

        if (accept) begin
            hold_dat_nxt  = tx_data;
            hold_full_nxt = 1'b1;
        end else if (load) begin
            hold_full_nxt = 1'b0;
        end

        case (state_nxt)
            S_START:  tx_nxt = 1'b0;
            S_BREAK:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = shreg_nxt[0];
            S_PARITY: tx_nxt = par_nxt;
            default:  tx_nxt = 1'b1;
        endcase
    end

    // State and datapath registers; reset returns the line to mark at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            brk_cnt   <= '0;
            hold_dat  <= '0;
            hold_full <= 1'b0;
            tx        <= 1'b1;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            shreg     <= shreg_nxt;
            par_bit   <= par_nxt;
            brk_cnt   <= brk_nxt;
            hold_dat  <= hold_dat_nxt;
            hold_full <= hold_full_nxt;
            tx        <= tx_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Purpose: bench for uart_tx_param across 8N1, 8E1, 8O1 and 7N2 instances (DIV = 16).
// Latency: frames are compared bit-by-bit against a bit-list model, each bit held for DIV cycles.
// Backpressure: drives valid and holds data until tx_ready is seen, including back-to-back transfers.
module tb_uart_tx_param;

    localparam int DIV  = 16;
    localparam int NDUT = 4;

    int db  [NDUT] = '{8, 8, 8, 7};
    int par [NDUT] = '{0, 2, 1, 0};
    int sb  [NDUT] = '{1, 1, 1, 2};

    logic       clk;
    logic       reset;
    logic [7:0] tx_data   [NDUT];
    logic       tx_valid  [NDUT];
    logic       break_req [NDUT];
    logic       tx_ready  [NDUT];
    logic       tx_o      [NDUT];
    logic       busy      [NDUT];

    int checks   = 0;
    int failures = 0;

    uart_tx_param #(.CLOCK(1600), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .reset(reset), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .break_req(break_req[0]), .tx(tx_o[0]), .busy(busy[0]));
    uart_tx_param #(.CLOCK(1600), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .reset(reset), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .break_req(break_req[1]), .tx(tx_o[1]), .busy(busy[1]));
    uart_tx_param #(.CLOCK(1600), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .reset(reset), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .break_req(break_req[2]), .tx(tx_o[2]), .busy(busy[2]));
    uart_tx_param #(.CLOCK(1600), .BAUD(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .reset(reset), .tx_data(tx_data[3][6:0]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready[3]), .break_req(break_req[3]), .tx(tx_o[3]), .busy(busy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: list of line bits for one frame, LSB first; returns the bit count.
    function automatic int build_frame(input int k, input logic [7:0] d, output logic [31:0] bits);
        int n;
        int ones;
        n    = 0;
        ones = 0;
        bits = '0;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < db[k]; i++) begin
            bits[n] = d[i];
            ones += int'(d[i]);
            n++;
        end
        if (par[k] == 2) begin
            bits[n] = (ones % 2 == 1);
            n++;
        end else if (par[k] == 1) begin
            bits[n] = (ones % 2 == 0);
            n++;
        end
        for (int i = 0; i < sb[k]; i++) begin
            bits[n] = 1'b1;
            n++;
        end
        return n;
    endfunction

    // Records each bit period's level, or X if the level moved inside the period.
    task automatic sample_bits(input int k, input int n, output logic [31:0] got);
        logic first;
        bit   steady;
        got = '0;
        for (int b = 0; b < n; b++) begin
            first  = tx_o[k];
            steady = 1'b1;
            for (int c = 0; c < DIV; c++) begin
                if (tx_o[k] !== first) steady = 1'b0;
                @(negedge clk);
            end
            got[b] = steady ? first : 1'bx;
        end
    endtask

    task automatic count_low(input int k, input int n, output int lows);
        lows = 0;
        for (int c = 0; c < n; c++) begin
            if (tx_o[k] === 1'b0) lows++;
            @(negedge clk);
        end
    endtask

    // Offers one word; returns at the negedge after the accepting edge with valid dropped.
    task automatic push(input int k, input logic [7:0] d, output bit ok);
        int n;
        tx_data[k]  = d;
        tx_valid[k] = 1'b1;
        n = 0;
        while (tx_ready[k] !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 1000);
        @(negedge clk);
        tx_valid[k] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            tx_data[k]   = '0;
            tx_valid[k]  = 1'b0;
            break_req[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (tx_o[k] !== 1'b1) begin failures++; $display("FAIL reset_tx dut%0d got=%b exp=1", k, tx_o[k]); end
            checks++;
            if (tx_ready[k] !== 1'b1) begin failures++; $display("FAIL reset_ready dut%0d got=%b exp=1", k, tx_ready[k]); end
            checks++;
            if (busy[k] !== 1'b0) begin failures++; $display("FAIL reset_busy dut%0d got=%b exp=0", k, busy[k]); end
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame_8n1();
        bit ok;
        int n;
        logic [31:0] exp_bits, got;
        push(0, 8'h55, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL 8n1_accept timeout got=0 exp=1"); end
        checks++;
        if (tx_ready[0] !== 1'b0) begin failures++; $display("FAIL 8n1_ready_after_accept got=%b exp=0", tx_ready[0]); end
        checks++;
        if (tx_o[0] !== 1'b1) begin failures++; $display("FAIL 8n1_tx_before_start got=%b exp=1", tx_o[0]); end
        checks++;
        if (busy[0] !== 1'b1) begin failures++; $display("FAIL 8n1_busy_hold got=%b exp=1", busy[0]); end
        @(negedge clk);
        checks++;
        if (tx_ready[0] !== 1'b1) begin failures++; $display("FAIL 8n1_ready_at_start got=%b exp=1", tx_ready[0]); end
        n = build_frame(0, 8'h55, exp_bits);
        sample_bits(0, n, got);
        checks++;
        if (got !== exp_bits) begin failures++; $display("FAIL 8n1_frame_55 got=%b exp=%b", got, exp_bits); end
        checks++;
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL 8n1_busy_end got=%b exp=0", busy[0]); end
    endtask

    task automatic test_fixed_formats();
        bit ok;
        int n;
        int ks [3] = '{1, 2, 3};
        logic [7:0] ds [3] = '{8'h07, 8'h07, 8'h7F};
        logic [31:0] exp_bits, got;
        for (int i = 0; i < 3; i++) begin
            push(ks[i], ds[i], ok);
            @(negedge clk);
            n = build_frame(ks[i], ds[i], exp_bits);
            sample_bits(ks[i], n, got);
            checks++;
            if (!ok || got !== exp_bits) begin
                failures++;
                $display("FAIL format_dut%0d data=%h got=%b exp=%b accepted=%0d", ks[i], ds[i], got, exp_bits, ok);
            end
            checks++;
            if (busy[ks[i]] !== 1'b0) begin failures++; $display("FAIL format_busy_dut%0d got=%b exp=0", ks[i], busy[ks[i]]); end
        end
    endtask

    task automatic test_random_frames();
        bit ok;
        int n, k;
        logic [7:0] d;
        logic [31:0] exp_bits, got;
        for (int i = 0; i < 12; i++) begin
            k = $urandom_range(0, NDUT - 1);
            d = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 20)) @(negedge clk);
            push(k, d, ok);
            @(negedge clk);
            n = build_frame(k, d, exp_bits);
            sample_bits(k, n, got);
            checks++;
            if (!ok || got !== exp_bits) begin
                failures++;
                $display("FAIL random_dut%0d data=%h got=%b exp=%b accepted=%0d", k, d, got, exp_bits, ok);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2, w;
        bit tmo1, tmo2;
        logic [31:0] e1, e2, exp_bits, got;
        n1 = build_frame(0, 8'hA5, e1);
        n2 = build_frame(0, 8'h3C, e2);
        exp_bits = e1 | (e2 << n1);
        tx_data[0]  = 8'hA5;
        tx_valid[0] = 1'b1;
        w = 0;
        while (tx_ready[0] !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
        tmo1 = (w >= 1000);
        @(negedge clk);
        tx_data[0] = 8'h3C;
        @(negedge clk);
        tmo2 = 1'b0;
        fork
            begin
                int m;
                m = 0;
                while (tx_ready[0] !== 1'b1 && m < 1000) begin @(negedge clk); m++; end
                tmo2 = (m >= 1000);
                @(negedge clk);
                tx_valid[0] = 1'b0;
            end
            sample_bits(0, n1 + n2, got);
        join
        checks++;
        if (tmo1 || tmo2) begin failures++; $display("FAIL b2b_accept timeout got=%0d%0d exp=00", tmo1, tmo2); end
        checks++;
        if (got !== exp_bits) begin failures++; $display("FAIL b2b_frames got=%b exp=%b", got, exp_bits); end
        checks++;
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b exp=0", busy[0]); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int n;
        logic [31:0] exp_bits, got;
        push(0, 8'hF0, ok);
        @(negedge clk);
        repeat (DIV + 3 * DIV + 5) @(negedge clk);
        checks++;
        if (tx_o[0] !== 1'b0) begin failures++; $display("FAIL midreset_bit3 got=%b exp=0", tx_o[0]); end
        reset = 1'b1;
        #1;
        checks++;
        if (tx_o[0] !== 1'b1) begin failures++; $display("FAIL midreset_tx got=%b exp=1", tx_o[0]); end
        checks++;
        if (tx_ready[0] !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b exp=1", tx_ready[0]); end
        checks++;
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy[0]); end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        push(0, 8'h81, ok);
        @(negedge clk);
        n = build_frame(0, 8'h81, exp_bits);
        sample_bits(0, n, got);
        checks++;
        if (!ok || got !== exp_bits) begin failures++; $display("FAIL midreset_frame_81 got=%b exp=%b accepted=%0d", got, exp_bits, ok); end
    endtask

    task automatic test_break();
        int l1, l2, n;
        bit ok;
        logic [31:0] exp_bits, got;
        // Single-cycle request: one frame time low, one stop bit high.
        break_req[0] = 1'b1;
        @(negedge clk);
        break_req[0] = 1'b0;
        count_low(0, 160, l1);
        checks++;
        if (busy[0] !== 1'b1) begin failures++; $display("FAIL brk_pulse_busy_stop got=%b exp=1", busy[0]); end
        count_low(0, 16, l2);
        checks++;
        if (l1 != 160 || l2 != 0) begin failures++; $display("FAIL brk_pulse lows=%0d/%0d exp=160/0", l1, l2); end
        checks++;
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL brk_pulse_busy_end got=%b exp=0", busy[0]); end

        // Held request: low for as long as it is held.
        break_req[0] = 1'b1;
        fork
            begin repeat (300) @(negedge clk); break_req[0] = 1'b0; end
            begin @(negedge clk); count_low(0, 300, l1); count_low(0, 16, l2); end
        join
        checks++;
        if (l1 != 300 || l2 != 0) begin failures++; $display("FAIL brk_held lows=%0d/%0d exp=300/0", l1, l2); end
        checks++;
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL brk_held_busy_end got=%b exp=0", busy[0]); end

        // A word already held in IDLE beats a break request.
        tx_data[0]  = 8'h33;
        tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0]  = 1'b0;
        break_req[0] = 1'b1;
        @(negedge clk);
        break_req[0] = 1'b0;
        n = build_frame(0, 8'h33, exp_bits);
        sample_bits(0, n, got);
        checks++;
        if (got !== exp_bits) begin failures++; $display("FAIL brk_priority got=%b exp=%b", got, exp_bits); end

        // Word accepted during a break is sent right after the trailing stop bit.
        break_req[0] = 1'b1;
        @(negedge clk);
        break_req[0] = 1'b0;
        n = build_frame(0, 8'h5A, exp_bits);
        ok = 1'b0;
        fork
            begin repeat (20) @(negedge clk); push(0, 8'h5A, ok); end
            begin count_low(0, 160, l1); count_low(0, 16, l2); sample_bits(0, n, got); end
        join
        checks++;
        if (!ok || l1 != 160 || l2 != 0) begin failures++; $display("FAIL brk_hold lows=%0d/%0d exp=160/0 accepted=%0d", l1, l2, ok); end
        checks++;
        if (got !== exp_bits) begin failures++; $display("FAIL brk_hold_frame got=%b exp=%b", got, exp_bits); end
        checks++;
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL brk_hold_busy_end got=%b exp=0", busy[0]); end
    endtask

    initial begin
        test_reset();
        test_frame_8n1();
        test_fixed_formats();
        test_back_to_back();
        test_reset_midframe();
        test_break();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
